// File: rtl/sample_tick_gen.sv
// sample_tick_gen
// Multi-channel programmable strobe / slow-clock generator. Each channel
// counts Clk_50MHz cycles up to its divider and emits a one-cycle tick plus
// a 50%-duty square wave. Divider writes to a running channel are held
// until the end of the current period, so output periods never glitch.
module sample_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 625000
) (
  input  logic              Clk_50MHz,
  input  logic              Reset_N,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_clk,
  output logic [NUM_CH-1:0] div_pending
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  act_div  [NUM_CH];
  logic [CNT_W-1:0]  pend_div [NUM_CH];
  logic [CNT_W-1:0]  eff_div  [NUM_CH];
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] commit;
  logic [NUM_CH-1:0] tick_nxt;

  // Per-channel effective divider, terminal-cycle and config-select decode.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    term     = '0;
    cfg_hit  = '0;
    commit   = '0;
    tick_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_div[i] = act_div[i];
      if (act_div[i] == '0) begin
        eff_div[i] = ONE;
      end
      term[i]     = ch_en[i] && (cnt[i] == eff_div[i] - ONE);
      // Out-of-range cfg_ch never matches any channel, so the write is dropped.
      cfg_hit[i]  = cfg_we && (cfg_ch == 3'(i));
      // Points where the counter is at 0 afterwards, so a new divider can
      // take effect without shortening or stretching a period.
      commit[i]   = sync_restart || !ch_en[i] || term[i];
      tick_nxt[i] = term[i] && !sync_restart;
    end
  end

  // Channel counters, divider staging and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of code order.
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      // NOTE: the per-channel arrays are a handful of flops rather than a RAM,
      // so they are reset explicitly; the divider must come up at its default.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        act_div[i]  <= DIV_RST;
        pend_div[i] <= DIV_RST;
      end
      tick        <= '0;
      sq_clk      <= '0;
      div_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit[i]) begin
          cnt[i]         <= '0;
          div_pending[i] <= 1'b0;
          tick[i]        <= tick_nxt[i];
          // Restart or disable forces the square wave low; a plain terminal
          // cycle toggles it.
          sq_clk[i]      <= tick_nxt[i] ? ~sq_clk[i] : 1'b0;
          if (cfg_hit[i]) begin
            act_div[i]  <= cfg_div;
            pend_div[i] <= cfg_div;
          end else begin
            // pend_div mirrors act_div whenever nothing is pending.
            act_div[i]  <= pend_div[i];
          end
        end else begin
          cnt[i]  <= cnt[i] + ONE;
          tick[i] <= 1'b0;
          if (cfg_hit[i]) begin
            pend_div[i]    <= cfg_div;
            div_pending[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_tick_gen.sv
// tb_sample_tick_gen
// Directed bench for sample_tick_gen with a reduced DEFAULT_DIV so that the
// reset-default period fits in a short run.
module tb_sample_tick_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int DEF    = 20;

  logic              Clk_50MHz = 1'b0;
  logic              Reset_N   = 1'b0;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic              sync_restart = 1'b0;
  logic              cfg_we    = 1'b0;
  logic [2:0]        cfg_ch    = '0;
  logic [CNT_W-1:0]  cfg_div   = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_clk;
  logic [NUM_CH-1:0] div_pending;

  int checks = 0;
  int errors = 0;

  sample_tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .Clk_50MHz    (Clk_50MHz),
    .Reset_N      (Reset_N),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .tick         (tick),
    .sq_clk       (sq_clk),
    .div_pending  (div_pending)
  );

  always #10 Clk_50MHz = ~Clk_50MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: each channel tracks elapsed cycles of its current
  // period and the period length; a period ends after D enabled cycles.
  // ---------------------------------------------------------------------
  int unsigned m_elapsed [NUM_CH];
  int unsigned m_period  [NUM_CH];   // programmed divider in use
  int unsigned m_next    [NUM_CH];   // divider to use from next period on
  bit          m_pending [NUM_CH];
  bit          m_sq      [NUM_CH];
  bit          m_tick    [NUM_CH];

  always @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_elapsed[c] = 0; m_period[c] = DEF; m_next[c] = DEF;
        m_pending[c] = 0; m_sq[c] = 0;       m_tick[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        int unsigned len;
        bit          wr;
        bit          period_done;
        len = (m_period[c] == 0) ? 1 : m_period[c];
        wr  = cfg_we && (int'(cfg_ch) == c);
        period_done = ch_en[c] && (m_elapsed[c] + 1 == len);
        if (sync_restart || !ch_en[c] || period_done) begin
          m_tick[c] = period_done && !sync_restart;
          m_sq[c]   = m_tick[c] ? !m_sq[c] : 1'b0;
          if (wr) m_next[c] = cfg_div;
          m_period[c]  = m_next[c];
          m_pending[c] = 0;
          m_elapsed[c] = 0;
        end else begin
          m_tick[c] = 0;
          m_elapsed[c]++;
          if (wr) begin
            m_next[c]    = cfg_div;
            m_pending[c] = 1;
          end
        end
      end
    end
  end

  // Compare process: outputs vs model on every falling edge out of reset.
  always @(negedge Clk_50MHz) begin
    if (Reset_N) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("model tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
        check($sformatf("model sq_clk[%0d]", c), 32'(sq_clk[c]), 32'(m_sq[c]));
        check($sformatf("model div_pending[%0d]", c), 32'(div_pending[c]), 32'(m_pending[c]));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all driven just after a falling edge)
  // ---------------------------------------------------------------------
  task automatic cfg_write(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_div = CNT_W'(div);
    @(negedge Clk_50MHz);
    cfg_we  = 1'b0;
  endtask

  // Number of rising edges until tick[ch] is seen high (bounded).
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      @(negedge Clk_50MHz);
      n++;
    end while (!tick[ch] && n < limit);
    if (!tick[ch]) n = -1;
  endtask

  // Number of rising edges until sq_clk[ch] equals lvl (bounded).
  task automatic wait_sq(input int ch, input bit lvl, input int limit, output int n);
    n = 0;
    do begin
      @(negedge Clk_50MHz);
      n++;
    end while (sq_clk[ch] != lvl && n < limit);
    if (sq_clk[ch] != lvl) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first0, first1, common;
    bit prev_sq;

    // 1. Reset state, then default period on all channels.
    ch_en = 4'hF;
    repeat (2) @(negedge Clk_50MHz);
    check("reset tick", 32'(tick), 0);
    check("reset sq_clk", 32'(sq_clk), 0);
    check("reset div_pending", 32'(div_pending), 0);
    Reset_N = 1'b1;
    wait_tick(0, 100, n);
    check("first default tick", n, DEF);
    check("all channels tick together", 32'(tick), 32'hF);
    wait_sq(0, 1'b0, 100, n);
    check("default sq high width", n, DEF);

    // 2. Divider write mid-period on running ch0 waits for the old terminal.
    repeat (5) @(negedge Clk_50MHz);
    cfg_write(0, 10);
    check("ch0 pending after write", 32'(div_pending[0]), 1);
    wait_tick(0, 100, n);
    check("ch0 old period completes", n, 14);
    check("ch0 pending cleared", 32'(div_pending[0]), 0);
    wait_tick(0, 100, n);
    check("ch0 new period a", n, 10);
    wait_sq(0, ~sq_clk[0], 100, n);
    check("ch0 new sq half", n, 10);

    // 3. Divider 0 then 1 on ch1 while disabled: tick stuck high, sq = clk/2.
    ch_en[1] = 1'b0;
    @(negedge Clk_50MHz);
    cfg_write(1, 0);
    check("ch1 disabled no pending", 32'(div_pending[1]), 0);
    ch_en[1] = 1'b1;
    @(negedge Clk_50MHz);
    prev_sq = sq_clk[1];
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk_50MHz);
      check("ch1 div0 tick high", 32'(tick[1]), 1);
      check("ch1 div0 sq toggles", 32'(sq_clk[1]), 32'(!prev_sq));
      prev_sq = sq_clk[1];
    end
    ch_en[1] = 1'b0;
    @(negedge Clk_50MHz);
    check("ch1 disabled sq low", 32'(sq_clk[1]), 0);
    cfg_write(1, 1);
    ch_en[1] = 1'b1;
    @(negedge Clk_50MHz);
    prev_sq = sq_clk[1];
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk_50MHz);
      check("ch1 div1 tick high", 32'(tick[1]), 1);
      check("ch1 div1 sq toggles", 32'(sq_clk[1]), 32'(!prev_sq));
      prev_sq = sq_clk[1];
    end

    // 4. ch0=7, ch1=5 then sync_restart: ticks at +7, +5, common at +35.
    ch_en = 4'b1100;
    @(negedge Clk_50MHz);
    cfg_write(0, 7);
    cfg_write(1, 5);
    ch_en = 4'hF;
    repeat (3) @(negedge Clk_50MHz);
    sync_restart = 1'b1;
    @(negedge Clk_50MHz);
    sync_restart = 1'b0;
    check("restart sq low", 32'(sq_clk), 0);
    first0 = -1; first1 = -1; common = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk_50MHz);
      if (tick[0] && first0 < 0) first0 = k;
      if (tick[1] && first1 < 0) first1 = k;
      if (tick[0] && tick[1] && common < 0) common = k;
    end
    check("restart ch0 first tick", first0, 7);
    check("restart ch1 first tick", first1, 5);
    check("restart common tick", common, 35);

    // 5. Out-of-range channel write is ignored; write on ch2 terminal cycle.
    cfg_write(6, 3);
    check("bad channel no pending", 32'(div_pending), 0);
    n = 0;
    while (m_elapsed[2] != DEF - 1 && n < 100) begin
      @(negedge Clk_50MHz);
      n++;
    end
    check("found ch2 terminal", 32'(m_elapsed[2]), DEF - 1);
    cfg_write(2, 4);
    check("ch2 terminal tick", 32'(tick[2]), 1);
    check("ch2 terminal write no pending", 32'(div_pending[2]), 0);
    wait_tick(2, 100, n);
    check("ch2 next period uses new div", n, 4);

    // 6. Asynchronous reset between edges, then default period again.
    @(posedge Clk_50MHz);
    #3 Reset_N = 1'b0;
    #1;
    check("async reset tick", 32'(tick), 0);
    check("async reset sq_clk", 32'(sq_clk), 0);
    check("async reset div_pending", 32'(div_pending), 0);
    @(negedge Clk_50MHz);
    Reset_N = 1'b1;
    wait_tick(2, 100, n);
    check("post-reset first tick", n, DEF);

    repeat (2) @(negedge Clk_50MHz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
